arf_ctrl: RTL and testbench

//  Sequencer for the 8-bit address register file (ARF: AR, SP, PCPrev, PC). Takes one

---
 rtl/arf_pkg.sv | 43 ++++
 rtl/arf_ctrl_step.sv | 117 +++++++++++
 rtl/arf_ctrl.sv | 144 ++++++++++++++
 tb/tb_arf_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arf_pkg.sv
// Package: arf_pkg
// Opcodes, ARF control codes and controller state encoding shared by arf_ctrl
// and its step decoder. Optional build macro used by the design:
// ARF_CTRL_STACK_GUARD_EN.
package arf_pkg;

    typedef enum logic [2:0] {
        OP_CLR   = 3'b000,
        OP_LDPC  = 3'b001,
        OP_LDAR  = 3'b010,
        OP_LDSP  = 3'b011,
        OP_FETCH = 3'b100,
        OP_PUSH  = 3'b101,
        OP_POP   = 3'b110,
        OP_RET   = 3'b111
    } op_e;

    localparam logic [1:0] FUNSEL_CLR  = 2'b00;
    localparam logic [1:0] FUNSEL_LOAD = 2'b01;
    localparam logic [1:0] FUNSEL_DEC  = 2'b10;
    localparam logic [1:0] FUNSEL_INC  = 2'b11;

    localparam logic [3:0] RSEL_NONE   = 4'b0000;
    localparam logic [3:0] RSEL_PC     = 4'b0001;
    localparam logic [3:0] RSEL_PCPREV = 4'b0010;
    localparam logic [3:0] RSEL_SP     = 4'b0100;
    localparam logic [3:0] RSEL_AR     = 4'b1000;
    localparam logic [3:0] RSEL_ALL    = 4'b1111;

    localparam logic [1:0] SEL_AR     = 2'b00;
    localparam logic [1:0] SEL_SP     = 2'b01;
    localparam logic [1:0] SEL_PCPREV = 2'b10;
    localparam logic [1:0] SEL_PC     = 2'b11;

    typedef enum logic [2:0] {
        ST_RST_CLR,
        ST_RST_SP,
        ST_IDLE,
        ST_EXEC1,
        ST_EXEC2
    } state_e;

endpackage

// File: rtl/arf_ctrl_step.sv
// Module: arf_ctrl_step
// Combinational decoder from (latched opcode, execution step) to one ARF
// control word plus memory strobes. 'last' marks the final step of a command.
// With ARF_CTRL_STACK_GUARD_EN defined, PUSH/POP check SP against the stack
// bounds in their first step and abort with 'fault' instead of touching SP.
module arf_ctrl_step
    import arf_pkg::*;
#(
    parameter int WIDTH = 8
`ifdef ARF_CTRL_STACK_GUARD_EN
    ,
    parameter logic [WIDTH-1:0] STACK_TOP   = 8'hFF,
    parameter logic [WIDTH-1:0] STACK_LIMIT = 8'h80
`endif
) (
    input  logic [2:0]       op,
    input  logic             second,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] out_a,
    output logic [1:0]       funsel,
    output logic [3:0]       r_sel,
    output logic [1:0]       out_a_sel,
    output logic [WIDTH-1:0] i,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             last,
    output logic             fault
);

    // Control word for the current step; single-step commands keep last=1
    always_comb begin
        funsel    = FUNSEL_CLR;
        r_sel     = RSEL_NONE;
        out_a_sel = SEL_AR;
        i         = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        last      = 1'b1;
        fault     = 1'b0;
        unique case (op_e'(op))
            OP_CLR: begin
                r_sel = RSEL_ALL;
            end
            OP_LDPC: begin
                funsel = FUNSEL_LOAD;
                r_sel  = RSEL_PC;
                i      = data;
            end
            OP_LDAR: begin
                funsel = FUNSEL_LOAD;
                r_sel  = RSEL_AR;
                i      = data;
            end
            OP_LDSP: begin
                funsel = FUNSEL_LOAD;
                r_sel  = RSEL_SP;
                i      = data;
            end
            OP_FETCH: begin
                if (!second) begin
                    out_a_sel = SEL_PC;
                    mem_rd    = 1'b1;
                    funsel    = FUNSEL_LOAD;
                    r_sel     = RSEL_PCPREV;
                    i         = out_a;
                    last      = 1'b0;
                end else begin
                    funsel = FUNSEL_INC;
                    r_sel  = RSEL_PC;
                end
            end
            OP_PUSH: begin
                if (!second) begin
                    funsel = FUNSEL_DEC;
                    r_sel  = RSEL_SP;
                    last   = 1'b0;
`ifdef ARF_CTRL_STACK_GUARD_EN
                    out_a_sel = SEL_SP;
                    if (out_a == STACK_LIMIT) begin
                        funsel = FUNSEL_CLR;
                        r_sel  = RSEL_NONE;
                        last   = 1'b1;
                        fault  = 1'b1;
                    end
`endif
                end else begin
                    out_a_sel = SEL_SP;
                    mem_wr    = 1'b1;
                end
            end
            OP_POP: begin
                if (!second) begin
                    out_a_sel = SEL_SP;
                    mem_rd    = 1'b1;
                    last      = 1'b0;
`ifdef ARF_CTRL_STACK_GUARD_EN
                    if (out_a == STACK_TOP) begin
                        mem_rd = 1'b0;
                        last   = 1'b1;
                        fault  = 1'b1;
                    end
`endif
                end else begin
                    funsel = FUNSEL_INC;
                    r_sel  = RSEL_SP;
                end
            end
            OP_RET: begin
                out_a_sel = SEL_PCPREV;
                funsel    = FUNSEL_LOAD;
                r_sel     = RSEL_PC;
                i         = out_a;
            end
        endcase
    end

endmodule

// File: rtl/arf_ctrl.sv
// Module: arf_ctrl
// Sequencer for the 8-bit address register file (AR, SP, PCPrev, PC). Runs a
// two-cycle init (clear all, load SP with STACK_TOP), then accepts one command
// at a time over valid/ready and plays it out as 1-2 ARF control words.
// Optional build macro: ARF_CTRL_STACK_GUARD_EN (stack bound checks, err output).
module arf_ctrl
    import arf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] STACK_TOP = 8'hFF
`ifdef ARF_CTRL_STACK_GUARD_EN
    ,
    parameter logic [WIDTH-1:0] STACK_LIMIT = 8'h80
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] arf_out_a,
    output logic [WIDTH-1:0] arf_i,
    output logic [1:0]       arf_funsel,
    output logic [3:0]       arf_r_sel,
    output logic [1:0]       arf_out_a_sel,
    output logic [1:0]       arf_out_b_sel,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             done,
    output logic             err
);

    state_e           state;
    state_e           state_next;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic             accept;

    logic [1:0]       step_funsel;
    logic [3:0]       step_r_sel;
    logic [1:0]       step_out_a_sel;
    logic [WIDTH-1:0] step_i;
    logic             step_mem_rd;
    logic             step_mem_wr;
    logic             step_last;
    logic             step_fault;

    assign mem_addr      = arf_out_a;
    assign arf_out_b_sel = SEL_PC;
    assign accept        = cmd_valid && cmd_ready;

    arf_ctrl_step #(
        .WIDTH       (WIDTH)
`ifdef ARF_CTRL_STACK_GUARD_EN
        ,
        .STACK_TOP   (STACK_TOP),
        .STACK_LIMIT (STACK_LIMIT)
`endif
    ) u_step (
        .op        (op_q),
        .second    (state == ST_EXEC2),
        .data      (data_q),
        .out_a     (arf_out_a),
        .funsel    (step_funsel),
        .r_sel     (step_r_sel),
        .out_a_sel (step_out_a_sel),
        .i         (step_i),
        .mem_rd    (step_mem_rd),
        .mem_wr    (step_mem_wr),
        .last      (step_last),
        .fault     (step_fault)
    );

    // State register; reset always restarts the init sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RST_CLR;
        end else begin
            state <= state_next;
        end
    end

    // Capture the accepted command so later input changes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            data_q <= '0;
        end else if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
        end
    end

    // Next state and control word; everything is held idle while rst_n is low
    always_comb begin
        state_next    = state;
        cmd_ready     = 1'b0;
        arf_funsel    = FUNSEL_CLR;
        arf_r_sel     = RSEL_NONE;
        arf_out_a_sel = SEL_AR;
        arf_i         = '0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        if (rst_n) begin
            unique case (state)
                ST_RST_CLR: begin
                    arf_r_sel  = RSEL_ALL;
                    state_next = ST_RST_SP;
                end
                ST_RST_SP: begin
                    arf_funsel = FUNSEL_LOAD;
                    arf_r_sel  = RSEL_SP;
                    arf_i      = STACK_TOP;
                    state_next = ST_IDLE;
                end
                ST_IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        state_next = ST_EXEC1;
                    end
                end
                ST_EXEC1, ST_EXEC2: begin
                    arf_funsel    = step_funsel;
                    arf_r_sel     = step_r_sel;
                    arf_out_a_sel = step_out_a_sel;
                    arf_i         = step_i;
                    mem_rd        = step_mem_rd;
                    mem_wr        = step_mem_wr;
                    done          = step_last;
                    err           = step_last && step_fault;
                    state_next    = step_last ? ST_IDLE : ST_EXEC2;
                end
                default: begin
                    state_next = ST_RST_CLR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arf_ctrl.sv
// Testbench: tb_arf_ctrl
// Drives arf_ctrl against a behavioural ARF and compares every command with a
// command-level reference model (register values, memory strobes, latency).
// Honours ARF_CTRL_STACK_GUARD_EN so the same bench covers both builds.
module tb_arf_ctrl;
    import arf_pkg::*;

`ifdef ARF_CTRL_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam logic [7:0] TOP_V   = 8'hFF;
    localparam logic [7:0] LIMIT_V = 8'h80;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] arf_out_a;
    logic [7:0] arf_i;
    logic [1:0] arf_funsel;
    logic [3:0] arf_r_sel;
    logic [1:0] arf_out_a_sel;
    logic [1:0] arf_out_b_sel;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic       done;
    logic       err;

    int total_checks = 0;
    int bad_checks   = 0;

    // Register file driven by the controller
    logic [7:0] r_ar, r_sp, r_pcp, r_pc;
    // Reference model registers
    logic [7:0] m_ar, m_sp, m_pcp, m_pc;

    typedef struct {
        int         cycles;
        logic       rd;
        logic [7:0] rd_addr;
        logic       wr;
        logic [7:0] wr_addr;
        logic       err;
    } exp_t;

    arf_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .arf_out_a     (arf_out_a),
        .arf_i         (arf_i),
        .arf_funsel    (arf_funsel),
        .arf_r_sel     (arf_r_sel),
        .arf_out_a_sel (arf_out_a_sel),
        .arf_out_b_sel (arf_out_b_sel),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] arf_next(input logic [1:0] f, input logic [7:0] cur,
                                            input logic [7:0] din);
        case (f)
            2'b00:   return 8'h00;
            2'b01:   return din;
            2'b10:   return cur - 8'd1;
            default: return cur + 8'd1;
        endcase
    endfunction

    // Behavioural ARF: writes land on the rising edge
    always_ff @(posedge clk) begin
        if (arf_r_sel[3]) r_ar  <= arf_next(arf_funsel, r_ar, arf_i);
        if (arf_r_sel[2]) r_sp  <= arf_next(arf_funsel, r_sp, arf_i);
        if (arf_r_sel[1]) r_pcp <= arf_next(arf_funsel, r_pcp, arf_i);
        if (arf_r_sel[0]) r_pc  <= arf_next(arf_funsel, r_pc, arf_i);
    end

    // ARF out_a read port
    always_comb begin
        case (arf_out_a_sel)
            2'b00:   arf_out_a = r_ar;
            2'b01:   arf_out_a = r_sp;
            2'b10:   arf_out_a = r_pcp;
            default: arf_out_a = r_pc;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_checks++;
        if (got !== want) begin
            bad_checks++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, "_ar"},  r_ar,  m_ar);
        checkOutput({tag, "_sp"},  r_sp,  m_sp);
        checkOutput({tag, "_pcp"}, r_pcp, m_pcp);
        checkOutput({tag, "_pc"},  r_pc,  m_pc);
    endtask

    // Command-level model: what each command does to the registers and memory
    task automatic modelCmd(input logic [2:0] op, input logic [7:0] d, output exp_t e);
        e.cycles = 1; e.rd = 1'b0; e.rd_addr = 8'h00;
        e.wr = 1'b0; e.wr_addr = 8'h00; e.err = 1'b0;
        case (op)
            3'd0: begin m_ar = 8'h00; m_sp = 8'h00; m_pcp = 8'h00; m_pc = 8'h00; end
            3'd1: m_pc = d;
            3'd2: m_ar = d;
            3'd3: m_sp = d;
            3'd4: begin
                e.cycles = 2; e.rd = 1'b1; e.rd_addr = m_pc;
                m_pcp = m_pc; m_pc = m_pc + 8'd1;
            end
            3'd5: begin
                if (GUARD && m_sp == LIMIT_V) e.err = 1'b1;
                else begin
                    e.cycles = 2; m_sp = m_sp - 8'd1;
                    e.wr = 1'b1; e.wr_addr = m_sp;
                end
            end
            3'd6: begin
                if (GUARD && m_sp == TOP_V) e.err = 1'b1;
                else begin
                    e.cycles = 2; e.rd = 1'b1; e.rd_addr = m_sp;
                    m_sp = m_sp + 8'd1;
                end
            end
            default: m_pc = m_pcp;
        endcase
    endtask

    // Offer one command, follow it to done, compare strobes, latency and registers.
    // Entered and left on a falling edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] d);
        exp_t e;
        int   n, cyc, rd_cnt, wr_cnt;
        logic [7:0] rd_addr, wr_addr;
        logic fin, err_seen;
        modelCmd(op, d, e);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        n = 0;
        while (!cmd_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept", cmd_ready, 1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_data = 8'($urandom);
        cyc = 0; rd_cnt = 0; wr_cnt = 0; rd_addr = 8'h00; wr_addr = 8'h00;
        fin = 1'b0; err_seen = 1'b0;
        for (int c = 1; c <= 4 && !fin; c++) begin
            if (c > 1) @(negedge clk);
            cyc = c;
            if (mem_rd) begin rd_cnt++; rd_addr = mem_addr; end
            if (mem_wr) begin wr_cnt++; wr_addr = mem_addr; end
            if (done) begin fin = 1'b1; err_seen = err; end
        end
        checkOutput("cycles", cyc, e.cycles);
        checkOutput("done_seen", fin, 1);
        checkOutput("rd_cnt", rd_cnt, 32'(e.rd));
        if (e.rd && rd_cnt == 1) checkOutput("rd_addr", rd_addr, e.rd_addr);
        checkOutput("wr_cnt", wr_cnt, 32'(e.wr));
        if (e.wr && wr_cnt == 1) checkOutput("wr_addr", wr_addr, e.wr_addr);
        checkOutput("err", err_seen, 32'(e.err));
        @(negedge clk);
        checkOutput("ready_after_done", cmd_ready, 1);
        checkRegs("regs");
    endtask

    // Release reset on a falling edge and check the two-cycle init
    task automatic releaseReset(input string tag);
        rst_n = 1'b1;
        #1;
        checkOutput({tag, "_ready_c0"}, cmd_ready, 0);
        @(negedge clk);
        checkOutput({tag, "_ready_c1"}, cmd_ready, 0);
        @(negedge clk);
        checkOutput({tag, "_ready_c2"}, cmd_ready, 1);
        m_ar = 8'h00; m_sp = TOP_V; m_pcp = 8'h00; m_pc = 8'h00;
        checkRegs(tag);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] bq_op [5];
        logic [7:0] bq_d  [5];
        logic [2:0] acc [$];
        exp_t       e;
        int         idx, donecnt;
        bit         pend;
        logic [7:0] pc_before, pcp_before;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_ready", cmd_ready, 0);
        checkOutput("rst_r_sel", arf_r_sel, 0);
        checkOutput("rst_funsel", arf_funsel, 0);
        checkOutput("rst_strobes", {mem_rd, mem_wr, done, err}, 0);
        checkOutput("out_b_sel", arf_out_b_sel, 2'b11);
        @(negedge clk);
        releaseReset("init");

        // Directed sequences
        applyStimulus(OP_LDPC, 8'h3C);
        applyStimulus(OP_FETCH, 8'h00);
        applyStimulus(OP_LDSP, 8'h81);
        applyStimulus(OP_PUSH, 8'h00);
        applyStimulus(OP_PUSH, 8'h00);
        applyStimulus(OP_LDPC, 8'hFF);
        applyStimulus(OP_FETCH, 8'h00);
        applyStimulus(OP_RET, 8'h00);
        applyStimulus(OP_LDSP, 8'hFF);
        applyStimulus(OP_POP, 8'h00);
        applyStimulus(OP_LDSP, 8'h00);
        applyStimulus(OP_PUSH, 8'h00);
        applyStimulus(OP_LDAR, 8'hA5);
        applyStimulus(OP_CLR, 8'h00);

        // Reset in the middle of a FETCH
        applyStimulus(OP_LDPC, 8'h5A);
        pc_before = r_pc; pcp_before = r_pcp;
        cmd_valid = 1'b1; cmd_op = OP_FETCH; cmd_data = 8'h00;
        checkOutput("midrst_offer_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("midrst_exec1_rd", mem_rd, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_r_sel", arf_r_sel, 0);
        checkOutput("midrst_strobes", {mem_rd, mem_wr, done, err}, 0);
        checkOutput("midrst_ready", cmd_ready, 0);
        @(negedge clk);
        checkOutput("midrst_pc", r_pc, pc_before);
        checkOutput("midrst_pcp", r_pcp, pcp_before);
        releaseReset("reinit");

        // Back-to-back with valid held high
        bq_op[0] = OP_LDAR;  bq_d[0] = 8'h11;
        bq_op[1] = OP_FETCH; bq_d[1] = 8'h00;
        bq_op[2] = OP_LDSP;  bq_d[2] = 8'h40;
        bq_op[3] = OP_POP;   bq_d[3] = 8'h00;
        bq_op[4] = OP_RET;   bq_d[4] = 8'h00;
        for (int k = 0; k < 5; k++) modelCmd(bq_op[k], bq_d[k], e);
        idx = 0; donecnt = 0; pend = 1'b0;
        cmd_valid = 1'b1; cmd_op = bq_op[0]; cmd_data = bq_d[0];
        for (int c = 0; c < 40 && donecnt < 5; c++) begin
            if (cmd_valid && cmd_ready) begin
                acc.push_back(cmd_op);
                idx++;
                pend = 1'b1;
            end
            @(negedge clk);
            if (pend) begin
                pend = 1'b0;
                if (idx < 5) begin
                    cmd_op = bq_op[idx]; cmd_data = bq_d[idx];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (done) donecnt++;
        end
        cmd_valid = 1'b0;
        checkOutput("b2b_done_cnt", donecnt, 5);
        checkOutput("b2b_accept_cnt", acc.size(), 5);
        for (int k = 0; k < 5 && k < acc.size(); k++)
            checkOutput($sformatf("b2b_order%0d", k), acc[k], bq_op[k]);
        @(negedge clk);
        checkRegs("b2b");

        // Randomized commands
        for (int t = 0; t < 150; t++) begin
            applyStimulus(3'($urandom_range(0, 7)), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
